rtc_burst_seq: RTL and testbench

//  Parametrised burst read/write sequencer for the RTC register bank.
//  One start pulse walks NREG consecutive RTC registers from BASE_ADDR through the bus-cycle engine:

---
 rtl/rtc_burst_seq_if.sv | 23 ++
 rtl/rtc_burst_seq.sv | 211 +++++++++++++++++++++
 tb/tb_rtc_burst_seq.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_burst_seq_if.sv
// Bus-cycle interface between the burst sequencer and the RTC bus-cycle engine.
// The master side issues request/write/address/data. The slave side returns ack and read data.
interface rtc_burst_seq_if #(
  parameter int DW = 8,
  parameter int AW = 8
) ();
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/rtc_burst_seq.sv
// Burst read/write sequencer for the RTC register bank.
// One start pulse walks NREG consecutive registers from BASE_ADDR through the bus-cycle engine.
// A read burst captures each returned byte into rd_data. A write burst sends a snapshot of wr_data.
// Every bus cycle is followed by a one-cycle gap with bus_req low.
// Optional feature: define RTC_SEQ_TIMEOUT_EN to abort a burst when an ack takes TO_CYC cycles.
// The abort raises the sticky error flag. Without the macro the sequencer waits for ack indefinitely.
module rtc_burst_seq #(
  parameter int            DW        = 8,
  parameter int            AW        = 8,
  parameter int            NREG      = 9,
  parameter logic [AW-1:0] BASE_ADDR = AW'(8'h21),
  parameter int            TO_CYC    = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 wr_mode,
  input  logic [NREG*DW-1:0]   wr_data,
  rtc_burst_seq_if.master      bus,
  output logic [NREG*DW-1:0]   rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  // idx needs at least one bit, so that NREG=1 still elaborates.
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IW-1:0]      idx_reg, idx_next;
  logic [IW-1:0]      idx_inc;
  logic               mode_reg, mode_next;
  logic [NREG*DW-1:0] wr_data_reg, wr_data_next;
  logic               bus_req_reg, bus_req_next;
  logic               bus_we_reg, bus_we_next;
  logic [AW-1:0]      bus_addr_reg, bus_addr_next;
  logic [DW-1:0]      bus_wdata_reg, bus_wdata_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               capture;
  logic [DW-1:0]      wr_word [NREG];
  logic [DW-1:0]      rd_word_reg [NREG];

`ifdef RTC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0] to_cnt_reg, to_cnt_next;
  logic          error_reg, error_next;
`endif

  // Split the latched write snapshot into per-register words, and pack the captured image back out.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_word
      assign wr_word[gi]              = wr_data_reg[gi*DW +: DW];
      assign rd_data[gi*DW +: DW]     = rd_word_reg[gi];
    end
  endgenerate

  assign idx_inc = idx_reg + IW'(1);

  // Next-state and next-output decode. All outputs are registered, so every _next follows its state change.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    mode_next      = mode_reg;
    wr_data_next   = wr_data_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    capture        = 1'b0;
`ifdef RTC_SEQ_TIMEOUT_EN
    to_cnt_next    = to_cnt_reg;
    error_next     = error_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next      = wr_mode;
          wr_data_next   = wr_data;
          idx_next       = '0;
          busy_next      = 1'b1;
          bus_req_next   = 1'b1;
          bus_we_next    = wr_mode;
          bus_addr_next  = BASE_ADDR;
          bus_wdata_next = wr_data[DW-1:0];
          state_next     = REQ;
`ifdef RTC_SEQ_TIMEOUT_EN
          to_cnt_next    = '0;
          error_next     = 1'b0;
`endif
        end
      end
      REQ: begin
        if (bus.bus_ack) begin
          capture      = ~mode_reg;
          bus_req_next = 1'b0;
          state_next   = GAP;
        end
`ifdef RTC_SEQ_TIMEOUT_EN
        else if (to_cnt_reg == CW'(TO_CYC - 1)) begin
          // This is the TO_CYC-th cycle without ack: abandon the rest of the burst.
          bus_req_next = 1'b0;
          error_next   = 1'b1;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          state_next   = DONE;
        end else begin
          to_cnt_next  = to_cnt_reg + CW'(1);
        end
`endif
      end
      GAP: begin
        if (idx_reg == IW'(NREG - 1)) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          idx_next       = idx_inc;
          bus_req_next   = 1'b1;
          bus_addr_next  = BASE_ADDR + AW'(idx_inc);
          bus_wdata_next = wr_word[idx_inc];
          state_next     = REQ;
`ifdef RTC_SEQ_TIMEOUT_EN
          to_cnt_next    = '0;
`endif
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      mode_reg      <= 1'b0;
      wr_data_reg   <= '0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      mode_reg      <= mode_next;
      wr_data_reg   <= wr_data_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  // Capture read data into the word addressed by idx; other words keep their previous value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        rd_word_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (capture && (idx_reg == IW'(i))) begin
          rd_word_reg[i] <= bus.bus_rdata;
        end
      end
    end
  end

`ifdef RTC_SEQ_TIMEOUT_EN
  // Ack timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      to_cnt_reg <= to_cnt_next;
      error_reg  <= error_next;
    end
  end

  assign error = error_reg;
`else
  // TO_CYC only matters when the timeout is built in.
  logic [31:0] unused_to_cyc;
  assign unused_to_cyc = TO_CYC;
  assign error         = 1'b0;
`endif

  assign bus.bus_req   = bus_req_reg;
  assign bus.bus_we    = bus_we_reg;
  assign bus.bus_addr  = bus_addr_reg;
  assign bus.bus_wdata = bus_wdata_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_rtc_burst_seq.sv
// Self-checking bench for rtc_burst_seq.
// Instance dut uses the default parameters (9 registers from 0x21).
// Instance dut2 uses 4 registers from 0xFE with TO_CYC=8, for address wrap and timeout.
// Expected bus cycles are queued when a burst starts and are popped when the engine model acks.
module tb_rtc_burst_seq;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int NREG  = 9;
  localparam int NREG2 = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start, wr_mode;
  logic [NREG*DW-1:0]   wr_data;
  logic [NREG*DW-1:0]   rd_data;
  logic                 busy, done, error;
  logic                 start2, wr_mode2;
  logic [NREG2*DW-1:0]  wr_data2;
  logic [NREG2*DW-1:0]  rd_data2;
  logic                 busy2, done2, error2;

  rtc_burst_seq_if #(.DW(DW), .AW(AW)) bif ();
  rtc_burst_seq_if #(.DW(DW), .AW(AW)) bif2 ();

  exp_t sb_q[$];
  exp_t sb2_q[$];
  int   checks = 0;
  int   errors = 0;

  // engine model settings for dut
  int            ack_delay;
  bit            ack_en;
  bit            spurious_en;
  logic [DW-1:0] rdata_base;
  int            req_cnt;
  int            done_cnt;

  logic [NREG*DW-1:0]  model_rd;
  logic [NREG2*DW-1:0] model_rd2;

  always #5 clk = ~clk;

  rtc_burst_seq #(.DW(DW), .AW(AW), .NREG(NREG), .BASE_ADDR(8'h21), .TO_CYC(255)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_mode(wr_mode), .wr_data(wr_data),
    .bus(bif), .rd_data(rd_data), .busy(busy), .done(done), .error(error)
  );

  rtc_burst_seq #(.DW(DW), .AW(AW), .NREG(NREG2), .BASE_ADDR(8'hFE), .TO_CYC(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .wr_mode(wr_mode2), .wr_data(wr_data2),
    .bus(bif2), .rd_data(rd_data2), .busy(busy2), .done(done2), .error(error2)
  );

  // Engine model for dut: acks after ack_delay cycles, checks hold-stability and pops the scoreboard.
  task automatic responder();
    logic          req_prev = 1'b0;
    int            waitc = 0;
    bit            ext = 1'b0;
    logic [AW-1:0] cap_addr = '0;
    logic          cap_we = 1'b0;
    logic [DW-1:0] cap_wd = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (reset) begin
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 8'hEE;
        req_prev      = 1'b0;
        waitc         = 0;
        ext           = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (bif.bus_req && !req_prev) begin
          req_cnt++;
          cap_addr = bif.bus_addr;
          cap_we   = bif.bus_we;
          cap_wd   = bif.bus_wdata;
          waitc    = 0;
        end else if (bif.bus_req) begin
          checks++;
          if ({bif.bus_addr, bif.bus_we, bif.bus_wdata} !== {cap_addr, cap_we, cap_wd}) begin
            errors++;
            $display("FAIL bus_hold: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                     bif.bus_addr, bif.bus_we, bif.bus_wdata, cap_addr, cap_we, cap_wd);
          end
        end
        req_prev = bif.bus_req;
        if (bif.bus_ack) begin
          if (spurious_en && !ext && !bif.bus_req) begin
            ext = 1'b1;  // keep ack high through the gap cycle
          end else begin
            bif.bus_ack   = 1'b0;
            bif.bus_rdata = 8'hEE;
            ext           = 1'b0;
          end
        end else if (bif.bus_req) begin
          if (ack_en && waitc >= ack_delay) begin
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL bus_cycle: unexpected cycle addr=%h, required none", bif.bus_addr);
            end else begin
              e = sb_q.pop_front();
              if (bif.bus_addr !== e.addr || bif.bus_we !== e.we || bif.bus_wdata !== e.wdata) begin
                errors++;
                $display("FAIL bus_cycle: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                         bif.bus_addr, bif.bus_we, bif.bus_wdata, e.addr, e.we, e.wdata);
              end
            end
            $display("bus cycle: addr=%h we=%b wdata=%h", bif.bus_addr, bif.bus_we, bif.bus_wdata);
            bif.bus_rdata = rdata_base + (bif.bus_addr - 8'h21);
            bif.bus_ack   = 1'b1;
          end
          waitc++;
        end
      end
    end
  endtask

  task automatic push_burst(input logic mode, input logic [NREG*DW-1:0] data);
    exp_t e;
    for (int i = 0; i < NREG; i++) begin
      e.addr  = AW'(8'h21 + i);
      e.we    = mode;
      e.wdata = data[i*DW +: DW];
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (cyc < max_cyc && !seen) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic start_burst(input logic mode, input logic [NREG*DW-1:0] data);
    @(negedge clk);
    start   = 1'b1;
    wr_mode = mode;
    wr_data = data;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bif.bus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b need 0", bif.bus_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b need 0", error); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd: got %h need 0", rd_data); end
    checks++; if ({bif.bus_addr, bif.bus_we, bif.bus_wdata} !== '0) begin
      errors++; $display("FAIL reset_bus: got %h/%b/%h need 0", bif.bus_addr, bif.bus_we, bif.bus_wdata);
    end
    checks++; if (bif2.bus_req !== 1'b0 || rd_data2 !== '0) begin
      errors++; $display("FAIL reset_dut2: req=%b rd=%h need 0", bif2.bus_req, rd_data2);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b need 0", busy); end
    model_rd  = '0;
    model_rd2 = '0;
    $display("test_reset done");
  endtask

  task automatic test_read_burst();
    logic [NREG*DW-1:0] wd;
    int r0, d0, cyc;
    bit seen;
    for (int i = 0; i < NREG; i++) wd[i*DW +: DW] = DW'($urandom);
    ack_delay = 1; ack_en = 1'b1; spurious_en = 1'b0; rdata_base = 8'h10;
    r0 = req_cnt; d0 = done_cnt;
    push_burst(1'b0, wd);
    start_burst(1'b0, wd);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy_start: got %b need 1", busy); end
    wait_done(200, cyc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL read_done_timeout: got no done need done"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_at_done: got %b need 0", busy); end
    for (int i = 0; i < NREG; i++) model_rd[i*DW +: DW] = DW'(8'h10 + i);
    checks++; if (rd_data !== model_rd) begin errors++; $display("FAIL read_rd: got %h need %h", rd_data, model_rd); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL read_done_pulse: got %b need 0", done); end
    checks++; if (req_cnt - r0 != NREG) begin errors++; $display("FAIL read_cycles: got %0d need %0d", req_cnt - r0, NREG); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL read_done_cnt: got %0d need 1", done_cnt - d0); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL read_sb_left: got %0d need 0", sb_q.size()); end
    $display("test_read_burst done");
  endtask

  task automatic test_min_timing();
    logic [NREG*DW-1:0] wd;
    int cyc;
    for (int i = 0; i < NREG; i++) wd[i*DW +: DW] = DW'($urandom);
    ack_delay = 0; rdata_base = 8'h40;
    push_burst(1'b0, wd);
    start_burst(1'b0, wd);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc != 2*NREG + 1) begin errors++; $display("FAIL min_timing: got done at cycle %0d need %0d", cyc, 2*NREG + 1); end
    for (int i = 0; i < NREG; i++) model_rd[i*DW +: DW] = DW'(8'h40 + i);
    checks++; if (rd_data !== model_rd) begin errors++; $display("FAIL min_timing_rd: got %h need %h", rd_data, model_rd); end
    @(negedge clk);
    $display("test_min_timing done");
  endtask

  task automatic test_write_burst();
    logic [NREG*DW-1:0] wd;
    int r0, cyc;
    bit seen;
    for (int i = 0; i < NREG; i++) wd[i*DW +: DW] = DW'(8'hA0 + i);
    ack_delay = 3; rdata_base = 8'h99;
    r0 = req_cnt;
    push_burst(1'b1, wd);
    start_burst(1'b1, wd);
    wr_data = ~wd;  // the burst must use the snapshot taken at start
    wait_done(400, cyc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL write_done_timeout: got no done need done"); end
    checks++; if (rd_data !== model_rd) begin errors++; $display("FAIL write_rd_kept: got %h need %h", rd_data, model_rd); end
    @(negedge clk);
    checks++; if (req_cnt - r0 != NREG) begin errors++; $display("FAIL write_cycles: got %0d need %0d", req_cnt - r0, NREG); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL write_sb_left: got %0d need 0", sb_q.size()); end
    $display("test_write_burst done");
  endtask

  task automatic test_back_to_back();
    logic [NREG*DW-1:0] wd;
    int r0, d0, cyc;
    bit seen;
    for (int i = 0; i < NREG; i++) wd[i*DW +: DW] = DW'($urandom);
    ack_delay = 1; spurious_en = 1'b1; rdata_base = 8'h30;
    r0 = req_cnt; d0 = done_cnt;
    push_burst(1'b0, wd);
    start_burst(1'b0, wd);
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start   = (cyc == 5 || cyc == 12);
      wr_mode = start;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_done_timeout: got no done need done"); end
    start = 1'b1;  // request during DONE must be ignored
    @(negedge clk);
    start = 1'b0; wr_mode = 1'b0;
    repeat (4) @(negedge clk);
    spurious_en = 1'b0;
    checks++; if (busy !== 1'b0 || bif.bus_req !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: busy=%b req=%b need 0/0", busy, bif.bus_req);
    end
    checks++; if (req_cnt - r0 != NREG) begin errors++; $display("FAIL b2b_cycles: got %0d need %0d", req_cnt - r0, NREG); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL b2b_done_cnt: got %0d need 1", done_cnt - d0); end
    for (int i = 0; i < NREG; i++) model_rd[i*DW +: DW] = DW'(8'h30 + i);
    checks++; if (rd_data !== model_rd) begin errors++; $display("FAIL b2b_rd: got %h need %h", rd_data, model_rd); end
    $display("test_back_to_back done");
  endtask

  task automatic test_no_ack_wait();
    logic [NREG*DW-1:0] wd;
    int cyc;
    bit seen;
    for (int i = 0; i < NREG; i++) wd[i*DW +: DW] = DW'($urandom);
    ack_delay = 0; ack_en = 1'b0; rdata_base = 8'h20;
    push_burst(1'b0, wd);
    start_burst(1'b0, wd);
    repeat (30) @(negedge clk);
    checks++; if (bif.bus_req !== 1'b1 || busy !== 1'b1 || bif.bus_addr !== 8'h21) begin
      errors++; $display("FAIL wait_hold: req=%b busy=%b addr=%h need 1/1/21", bif.bus_req, busy, bif.bus_addr);
    end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL wait_error: got %b need 0", error); end
    ack_en = 1'b1;
    wait_done(300, cyc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL wait_done_timeout: got no done need done"); end
    for (int i = 0; i < NREG; i++) model_rd[i*DW +: DW] = DW'(8'h20 + i);
    checks++; if (rd_data !== model_rd) begin errors++; $display("FAIL wait_rd: got %h need %h", rd_data, model_rd); end
    @(negedge clk);
    $display("test_no_ack_wait done");
  endtask

  task automatic test_reset_mid_burst();
    logic [NREG*DW-1:0] wd;
    logic prev;
    int nrise, cyc, d0;
    for (int i = 0; i < NREG; i++) wd[i*DW +: DW] = DW'($urandom);
    ack_delay = 1; rdata_base = 8'h70;
    push_burst(1'b0, wd);
    start_burst(1'b0, wd);
    prev = 1'b0; nrise = 0; cyc = 0;
    while (nrise < 4 && cyc < 100) begin
      if (bif.bus_req && !prev) nrise++;
      prev = bif.bus_req;
      if (nrise < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++; if (nrise != 4) begin errors++; $display("FAIL mid_reset_reach: got %0d reqs need 4", nrise); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bif.bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ctrl: req=%b busy=%b done=%b need 0/0/0", bif.bus_req, busy, done);
    end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL mid_reset_rd: got %h need 0", rd_data); end
    reset = 1'b0;
    model_rd  = '0;
    model_rd2 = '0;
    sb_q.delete();
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    checks++; if (done_cnt != d0 || busy !== 1'b0 || bif.bus_req !== 1'b0) begin
      errors++; $display("FAIL mid_reset_after: dones=%0d busy=%b req=%b need 0/0/0", done_cnt - d0, busy, bif.bus_req);
    end
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_addr_wrap();
    exp_t e;
    int k, cyc;
    bit seen;
    for (int i = 0; i < NREG2; i++) begin
      wr_data2[i*DW +: DW] = DW'($urandom);
      e.addr = AW'(8'hFE + i); e.we = 1'b0; e.wdata = wr_data2[i*DW +: DW];
      sb2_q.push_back(e);
    end
    @(negedge clk);
    start2 = 1'b1; wr_mode2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    k = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (done2 === 1'b1) seen = 1'b1;
      else if (bif2.bus_ack) bif2.bus_ack = 1'b0;
      else if (bif2.bus_req) begin
        checks++;
        if (sb2_q.size() == 0) begin
          errors++; $display("FAIL wrap_cycle: unexpected addr=%h, required none", bif2.bus_addr);
        end else begin
          e = sb2_q.pop_front();
          if (bif2.bus_addr !== e.addr || bif2.bus_we !== e.we || bif2.bus_wdata !== e.wdata) begin
            errors++; $display("FAIL wrap_cycle: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                               bif2.bus_addr, bif2.bus_we, bif2.bus_wdata, e.addr, e.we, e.wdata);
          end
        end
        $display("bus2 cycle: addr=%h we=%b", bif2.bus_addr, bif2.bus_we);
        bif2.bus_rdata = 8'h50 + (bif2.bus_addr - 8'hFE);
        bif2.bus_ack = 1'b1;
        k++;
      end
      if (!seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++; if (!seen || k != NREG2) begin errors++; $display("FAIL wrap_count: done=%b cycles=%0d need 1/%0d", seen, k, NREG2); end
    for (int i = 0; i < NREG2; i++) model_rd2[i*DW +: DW] = DW'(8'h50 + i);
    checks++; if (rd_data2 !== model_rd2) begin errors++; $display("FAIL wrap_rd: got %h need %h", rd_data2, model_rd2); end
    @(negedge clk);
    $display("test_addr_wrap done");
  endtask

`ifdef RTC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int stall, cyc, idx;
    bit seen;
    wr_data2 = '0;
    for (int i = 0; i < 2; i++) begin
      e.addr = AW'(8'hFE + i); e.we = 1'b0; e.wdata = '0;
      sb2_q.push_back(e);
    end
    @(negedge clk);
    start2 = 1'b1; wr_mode2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    stall = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      if (done2 === 1'b1) seen = 1'b1;
      else if (bif2.bus_ack) bif2.bus_ack = 1'b0;
      else if (bif2.bus_req) begin
        idx = int'(AW'(bif2.bus_addr - 8'hFE));
        if (idx == 2) stall++;
        else begin
          checks++;
          if (sb2_q.size() == 0) begin
            errors++; $display("FAIL to_cycle: unexpected addr=%h, required none", bif2.bus_addr);
          end else begin
            e = sb2_q.pop_front();
            if (bif2.bus_addr !== e.addr) begin
              errors++; $display("FAIL to_cycle: addr=%h, required %h", bif2.bus_addr, e.addr);
            end
          end
          bif2.bus_rdata = DW'(8'h60 + idx);
          bif2.bus_ack = 1'b1;
        end
      end
      if (!seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_done: got no done need done"); end
    checks++; if (stall != 8) begin errors++; $display("FAIL to_req_len: got %0d cycles need 8", stall); end
    checks++; if (error2 !== 1'b1 || busy2 !== 1'b0) begin errors++; $display("FAIL to_error: err=%b busy=%b need 1/0", error2, busy2); end
    model_rd2[0 +: DW]  = 8'h60;
    model_rd2[DW +: DW] = 8'h61;
    checks++; if (rd_data2 !== model_rd2) begin errors++; $display("FAIL to_rd: got %h need %h", rd_data2, model_rd2); end
    repeat (3) @(negedge clk);
    checks++; if (error2 !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b need 1", error2); end
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checks++; if (error2 !== 1'b0) begin errors++; $display("FAIL to_clear: got %b need 0", error2); end
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (done2 === 1'b1) seen = 1'b1;
      else if (bif2.bus_ack) bif2.bus_ack = 1'b0;
      else if (bif2.bus_req) begin
        bif2.bus_rdata = 8'h80 + (bif2.bus_addr - 8'hFE);
        bif2.bus_ack = 1'b1;
      end
      if (!seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    for (int i = 0; i < NREG2; i++) model_rd2[i*DW +: DW] = DW'(8'h80 + i);
    checks++; if (!seen || rd_data2 !== model_rd2 || error2 !== 1'b0) begin
      errors++; $display("FAIL to_rerun: done=%b rd=%h err=%b need 1/%h/0", seen, rd_data2, error2, model_rd2);
    end
    $display("test_timeout done");
  endtask
`else
  task automatic test_timeout();
    checks++; if (error2 !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL no_timeout_error: got %b/%b need 0/0", error, error2);
    end
    $display("test_timeout (feature absent) done");
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0; wr_mode = 1'b0; wr_data = '0;
    start2 = 1'b0; wr_mode2 = 1'b0; wr_data2 = '0;
    bif.bus_ack = 1'b0; bif.bus_rdata = '0;
    bif2.bus_ack = 1'b0; bif2.bus_rdata = '0;
    ack_delay = 0; ack_en = 1'b1; spurious_en = 1'b0; rdata_base = '0;
    req_cnt = 0; done_cnt = 0;
    model_rd = '0; model_rd2 = '0;
    fork
      responder();
    join_none
    test_reset();
    test_read_burst();
    test_min_timing();
    test_write_burst();
    test_back_to_back();
    test_no_ack_wait();
    test_reset_mid_burst();
    test_addr_wrap();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
